acc_mem_arbiter: RTL
====================

# acc_mem_arbiter

Shares the single accelerator-side Data Memory port among `NUM_ACC` accelerator control units. It takes each unit's read request (512-bit block fetch) and write request (32-bit word store), and serves one transaction at a time in round-robin order. Each response is returned as a one-cycle `*_read_data_valid` or `*_write_done` pulse. The CPU has absolute priority on the memory issue slot via `cpu_mem_en`.

## Interface
- `NUM_ACC`, 4, number of accelerator requesters (≥2)
- `ADDR_W`, 16, memory address width
- `RD_DATA_W`, 512, read data width
- `WR_DATA_W`, 32, write data width
- `MEM_RD_LATENCY`, 1, cycles from `mem_rd_en` to valid `mem_rd_data` (≥1)

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, synchronous, active-low
- `acc_read_en` in NUM_ACC: per-requester read request, level, held until valid pulse
- `acc_read_addr` in NUM_ACC*ADDR_W: packed read addresses, requester i at `[i*ADDR_W +: ADDR_W]`
- `acc_write_en` in NUM_ACC: per-requester write request, level, held until done pulse
- `acc_write_addr` in NUM_ACC*ADDR_W: packed write addresses
- `acc_write_data` in NUM_ACC*WR_DATA_W: packed write data
- `acc_read_data` out RD_DATA_W: registered read data, broadcast to all requesters
- `acc_read_data_valid` out NUM_ACC: one-hot, one-cycle read-complete pulse
- `acc_write_done` out NUM_ACC: one-hot, one-cycle write-complete pulse
- `cpu_mem_en` in 1: CPU owns the memory port this cycle
- `mem_rd_en` out 1: memory read strobe
- `mem_wr_en` out 1: memory write strobe
- `mem_addr` out ADDR_W: memory address
- `mem_wr_data` out WR_DATA_W: memory write data
- `mem_rd_data` in RD_DATA_W: memory read data
- `arb_busy` out 1: transaction in flight (state ≠ IDLE)
- `arb_grant_id` out clog2(NUM_ACC): latched grantee index

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any `acc_read_en|acc_write_en` is set, grant the first requester found searching from `rr_ptr` upward (mod NUM_ACC).
  - Latch grantee id, op, address and write data; go to ISSUE.
  - If the grantee has both read and write asserted, the read is served.
  - Arbitration in IDLE ignores `cpu_mem_en`.
- **ISSUE:**
  - If `cpu_mem_en` is high: stall in ISSUE with `mem_rd_en = mem_wr_en = 0`.
  - Otherwise drive `mem_addr` and assert `mem_rd_en` or `mem_wr_en` for exactly one cycle. Read → WAIT; write → RESP.
- **WAIT:** count `MEM_RD_LATENCY` cycles. On the final cycle, capture `mem_rd_data` into the `acc_read_data` register; go to RESP.
- **RESP:** pulse `acc_read_data_valid[id]` or `acc_write_done[id]` for one cycle; set `rr_ptr = (id+1) mod NUM_ACC`; go to IDLE.
  - No arbitration occurs in RESP. This prevents re-granting a requester whose enable is still high during its response cycle.
- **Fixed-at-latch rules:** once latched, address, data and op are fixed. A requester dropping its enable after the grant does not cancel the transaction; the pulse is still delivered. A request dropped before the grant is simply never served.
- `acc_read_data` holds its last captured value until the next read capture.
- `arb_grant_id` holds the latched grantee index and retains its value in IDLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, `rr_ptr` 0, `acc_read_data` 0, `arb_grant_id` 0.
  - Reset mid-transaction aborts it: no pulse is delivered and memory strobes drop in the next cycle.
- **Write, no CPU contention:** request seen in cycle T (IDLE), `mem_wr_en` at T+1, `acc_write_done` at T+2. Next grant is evaluated at T+3.
- **Read, no CPU contention:** `mem_rd_en` at T+1, data captured at end of T+1+MEM_RD_LATENCY, `acc_read_data_valid` with data at T+2+MEM_RD_LATENCY.
- Each cycle `cpu_mem_en` is high during ISSUE adds one cycle of latency. The arbiter never asserts `mem_*_en` in a cycle where `cpu_mem_en` is high.
- At most one of `mem_rd_en`/`mem_wr_en` is high per cycle. At most one bit of `acc_read_data_valid | acc_write_done` is high per cycle.
- Back-to-back throughput is one write per 3 cycles and one read per 3+MEM_RD_LATENCY cycles.

## Test plan
- **Single write:** req 2 writes `0x5008` / `0xDEADBEEF` at T → `mem_wr_en`, `mem_addr=0x5008`, `mem_wr_data=0xDEADBEEF` at T+1; `acc_write_done=4'b0100` at T+2.
- **Single read, latency 1:** req 0 reads `0x1000`, memory returns pattern `P` → `acc_read_data=P` with `acc_read_data_valid=4'b0001` at T+3; one pulse only, though `acc_read_en` stays high through T+3.
- **Round-robin:** all 4 requesters write continuously, `rr_ptr=0` → grants in order 0,1,2,3,0, with done pulses spaced every 3 cycles.
- **CPU priority:** `cpu_mem_en` high for 3 cycles starting at ISSUE → no `mem_*_en` during those cycles; strobe issues on the 4th cycle; done pulse is 3 cycles late.
- **Same requester read+write:** req 1 asserts both → read served first (`mem_rd_en`), write served in a later grant.
- **Reset mid-read:** `rst_n` low during WAIT → all outputs 0 next cycle, no valid pulse delivered, `rr_ptr=0`; a fresh request after reset completes normally.

Source files
------------

// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter sharing one Data Memory port among NUM_ACC accelerator units.
// Serves one read (block fetch) or write (word store) at a time; the CPU always wins the issue slot.
module acc_mem_arbiter #(
  parameter int NUM_ACC        = 4,
  parameter int ADDR_W         = 16,
  parameter int RD_DATA_W      = 512,
  parameter int WR_DATA_W      = 32,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_ACC-1:0]            acc_read_en,
  input  logic [NUM_ACC*ADDR_W-1:0]     acc_read_addr,
  input  logic [NUM_ACC-1:0]            acc_write_en,
  input  logic [NUM_ACC*ADDR_W-1:0]     acc_write_addr,
  input  logic [NUM_ACC*WR_DATA_W-1:0]  acc_write_data,
  output logic [RD_DATA_W-1:0]          acc_read_data,
  output logic [NUM_ACC-1:0]            acc_read_data_valid,
  output logic [NUM_ACC-1:0]            acc_write_done,
  input  logic                          cpu_mem_en,
  output logic                          mem_rd_en,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [WR_DATA_W-1:0]          mem_wr_data,
  input  logic [RD_DATA_W-1:0]          mem_rd_data,
  output logic                          arb_busy,
  output logic [$clog2(NUM_ACC)-1:0]    arb_grant_id
);

  localparam int ID_W  = $clog2(NUM_ACC);
  localparam int CNT_W = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q;
  logic [ID_W-1:0]        id_q;
  logic [ID_W-1:0]        rr_ptr_q;
  logic                   op_rd_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [WR_DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [RD_DATA_W-1:0]   rdata_q;
  logic [NUM_ACC-1:0]     rd_valid_q;
  logic [NUM_ACC-1:0]     wr_done_q;

  logic [NUM_ACC-1:0]     req;
  logic                   gnt_vld;
  logic [ID_W-1:0]        gnt_id;
  logic [NUM_ACC-1:0]     id_onehot;
  logic                   issue;

  assign req       = acc_read_en | acc_write_en;
  assign id_onehot = NUM_ACC'(1) << id_q;

  // Walk downward so the requester closest to rr_ptr_q is written last and wins.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = NUM_ACC - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_ACC;
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      op_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rd_valid_q <= '0;
      wr_done_q  <= '0;
    end else begin
      rd_valid_q <= '0;
      wr_done_q  <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            id_q    <= gnt_id;
            op_rd_q <= acc_read_en[gnt_id];
            addr_q  <= acc_read_en[gnt_id] ? acc_read_addr[gnt_id*ADDR_W +: ADDR_W]
                                           : acc_write_addr[gnt_id*ADDR_W +: ADDR_W];
            wdata_q <= acc_write_data[gnt_id*WR_DATA_W +: WR_DATA_W];
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!cpu_mem_en) begin
            if (op_rd_q) begin
              cnt_q   <= CNT_W'(MEM_RD_LATENCY - 1);
              state_q <= WAIT;
            end else begin
              wr_done_q <= id_onehot;
              state_q   <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rdata_q    <= mem_rd_data;
            rd_valid_q <= id_onehot;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          // No arbitration here: the grantee may still hold its enable this cycle.
          rr_ptr_q <= (id_q == ID_W'(NUM_ACC - 1)) ? '0 : id_q + ID_W'(1);
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes must see cpu_mem_en in the same cycle, so they are decoded from state.
  assign issue       = (state_q == ISSUE) && !cpu_mem_en;
  assign mem_rd_en   = issue && op_rd_q;
  assign mem_wr_en   = issue && !op_rd_q;
  assign mem_addr    = issue ? addr_q : '0;
  assign mem_wr_data = (issue && !op_rd_q) ? wdata_q : '0;

  assign acc_read_data       = rdata_q;
  assign acc_read_data_valid = rd_valid_q;
  assign acc_write_done      = wr_done_q;
  assign arb_busy            = (state_q != IDLE);
  assign arb_grant_id        = id_q;

endmodule
